// File: rtl/rr_slice_arbiter.sv
// Packet-aware N-to-1 round-robin arbiter feeding a full-throughput forward
// register stage; a winner keeps the channel until it sends its Last beat.
module rr_slice_arbiter #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int IW = 2
) (
  input  logic            clki,
  input  logic            rst,
  input  logic [N-1:0]    RxVld,
  input  logic [N*DW-1:0] RxData,
  input  logic [N-1:0]    RxLast,
  output logic [N-1:0]    RxRdy,
  output logic            TxVld,
  output logic [DW-1:0]   TxData,
  output logic            TxLast,
  output logic [IW-1:0]   TxId,
  input  logic            TxRdy
);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_rr_ptr;
  logic [IW-1:0] w_rr_ptr_nxt;
  logic [IW-1:0] r_lock_id;
  logic [IW-1:0] w_lock_id_nxt;
  logic [IW-1:0] w_rr_sel;
  logic [IW-1:0] w_sel;
  logic [IW-1:0] w_sel_inc;
  logic          w_load;
  logic          w_acc;
  logic [DW-1:0] w_rx_data [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_rx_data[i] = RxData[i*DW +: DW];
    end
  end

  // First valid requester at or after the round-robin pointer, wrapping mod N.
  always_comb begin
    logic [IW-1:0] idx;
    logic          found;
    w_rr_sel = r_rr_ptr;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(r_rr_ptr) + k) % N);
      if (!found && RxVld[idx]) begin
        w_rr_sel = idx;
        found    = 1'b1;
      end
    end
  end

  assign w_sel     = (r_state == ST_LOCKED) ? r_lock_id : w_rr_sel;
  assign w_sel_inc = (w_sel == IW'(N - 1)) ? '0 : w_sel + IW'(1);
  assign w_load    = ~TxVld | TxRdy;

  always_comb begin
    RxRdy = '0;
    if (w_load && !rst && RxVld[w_sel]) begin
      RxRdy[w_sel] = 1'b1;
    end
  end

  assign w_acc = |(RxVld & RxRdy);

  // Pointer moves only at packet end, so stalls never cost a requester its turn.
  always_comb begin
    w_state_nxt   = r_state;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_lock_id_nxt = r_lock_id;
    if (w_acc) begin
      if (RxLast[w_sel]) begin
        w_state_nxt  = ST_IDLE;
        w_rr_ptr_nxt = w_sel_inc;
      end else begin
        w_state_nxt   = ST_LOCKED;
        w_lock_id_nxt = w_sel;
      end
    end
  end

  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= '0;
      r_lock_id <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_lock_id <= w_lock_id_nxt;
    end
  end

  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      TxVld  <= 1'b0;
      TxData <= '0;
      TxLast <= 1'b0;
      TxId   <= '0;
    end else if (w_load) begin
      TxVld <= w_acc;
      if (w_acc) begin
        TxData <= w_rx_data[w_sel];
        TxLast <= RxLast[w_sel];
        TxId   <= w_sel;
      end
    end
  end

endmodule
